// File: rtl/pipe_dmem_sb_if.sv
// rtl/pipe_dmem_sb_if.sv - MEM-stage store/load, loader and debug signals of pipe_dmem_sb
interface pipe_dmem_sb_if #(
  parameter int AW  = 8,
  parameter int SBD = 4
);
  logic                   mwmem;
  logic [31:0]            malu;
  logic [31:0]            mb;
  logic [31:0]            mmo;
  logic                   sb_full;
  logic [$clog2(SBD):0]   sb_count;
  logic                   ld_we;
  logic [AW-1:0]          ld_addr;
  logic [31:0]            ld_data;
  logic [AW-1:0]          dbg_addr;
  logic [31:0]            dbg_data;

  modport master (
    output mwmem, malu, mb, ld_we, ld_addr, ld_data, dbg_addr,
    input  mmo, sb_full, sb_count, dbg_data
  );

  modport slave (
    input  mwmem, malu, mb, ld_we, ld_addr, ld_data, dbg_addr,
    output mmo, sb_full, sb_count, dbg_data
  );
endinterface

// File: rtl/pipe_dmem_sb.sv
// rtl/pipe_dmem_sb.sv - data memory with in-order store buffer, youngest-match load forwarding
// and a loader port that pre-empts buffer drain on the shared array write port.
module pipe_dmem_sb #(
  parameter int AW  = 8,
  parameter int SBD = 4
) (
  input  logic          clock,
  input  logic          resetn,
  pipe_dmem_sb_if.slave bus
);
  localparam int PW = $clog2(SBD);
  localparam int CW = PW + 1;

  logic [31:0]   mem     [2**AW];
  logic [AW-1:0] sb_addr [SBD];
  logic [31:0]   sb_data [SBD];
  logic [SBD-1:0] sb_vld;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [AW-1:0] widx;
  logic          push;
  logic          pop;
  logic          hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] fwd_idx;
  logic          unused_malu;

  assign widx        = bus.malu[AW+1:2];
  assign unused_malu = ^{bus.malu[31:AW+2], bus.malu[1:0]};

  assign bus.sb_full  = (count == CW'(SBD));
  assign bus.sb_count = count;

  // A full buffer refuses the store even when the head drains on the same edge.
  assign push = bus.mwmem && !bus.sb_full;
  assign pop  = (count != '0) && !bus.ld_we;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      sb_vld <= '0;
    end else begin
      if (pop) begin
        sb_vld[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        sb_vld[tail] <= 1'b1;
        tail         <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      sb_addr[tail] <= widx;
      sb_data[tail] <= bus.mb;
    end
  end

  always_ff @(posedge clock) begin
    if (bus.ld_we) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end else if (pop) begin
      mem[sb_addr[head]] <= sb_data[head];
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < SBD; i++) begin
      fwd_idx = head + PW'(i);
      if (sb_vld[fwd_idx] && (sb_addr[fwd_idx] == widx)) begin
        hit      = 1'b1;
        fwd_data = sb_data[fwd_idx];
      end
    end
  end

  assign bus.mmo      = hit ? fwd_data : mem[widx];
  assign bus.dbg_data = mem[bus.dbg_addr];
endmodule

// File: tb/tb_pipe_dmem_sb.sv
// tb/tb_pipe_dmem_sb.sv - directed and randomized checks of pipe_dmem_sb against a queue/array model
module tb_pipe_dmem_sb;
  localparam int AW  = 8;
  localparam int SBD = 4;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clock;
  logic resetn;
  pipe_dmem_sb_if #(.AW(AW), .SBD(SBD)) bus ();

  pipe_dmem_sb #(.AW(AW), .SBD(SBD)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ent_t        ref_q [$];
  logic [31:0] ref_mem [256];
  int          vectors;
  int          miscompares;
  bit          last_accept;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] addr);
    logic [7:0] w;
    w = addr[9:2];
    for (int i = ref_q.size() - 1; i >= 0; i--)
      if (ref_q[i].a == w) return ref_q[i].d;
    return ref_mem[w];
  endfunction

  task automatic tick();
    ent_t e;
    bit   accept;
    @(posedge clock);
    accept = bus.mwmem && (ref_q.size() < SBD);
    if (bus.ld_we) begin
      ref_mem[bus.ld_addr] = bus.ld_data;
    end else if (ref_q.size() > 0) begin
      ref_mem[ref_q[0].a] = ref_q[0].d;
      void'(ref_q.pop_front());
    end
    if (accept) begin
      e.a = bus.malu[9:2];
      e.d = bus.mb;
      ref_q.push_back(e);
    end
    last_accept = accept;
    #2;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mmo"},   bus.mmo,             exp_load(bus.malu));
    chk({tag, ".dbg"},   bus.dbg_data,        ref_mem[bus.dbg_addr]);
    chk({tag, ".count"}, 32'(bus.sb_count),   32'(ref_q.size()));
    chk({tag, ".full"},  32'(bus.sb_full),    32'(ref_q.size() == SBD));
  endtask

  task automatic drain();
    bus.mwmem = 1'b0;
    bus.ld_we = 1'b0;
    for (int k = 0; k < 20 && ref_q.size() > 0; k++) tick();
  endtask

  initial begin
    logic [31:0] r;
    vectors      = 0;
    miscompares  = 0;
    last_accept  = 1'b0;
    resetn       = 1'b0;
    bus.mwmem    = 1'b0;
    bus.malu     = '0;
    bus.mb       = '0;
    bus.ld_we    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.dbg_addr = '0;
    #3;
    chk("reset.count", 32'(bus.sb_count), 32'd0);
    chk("reset.full",  32'(bus.sb_full),  32'd0);
    resetn = 1'b1;

    // Fill the array so every load/debug read has a known value.
    bus.ld_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.ld_addr = 8'(i);
      bus.ld_data = $urandom;
      tick();
    end

    // Loader write and read-back
    bus.ld_addr = 8'd3;
    bus.ld_data = 32'h1111_1111;
    tick();
    bus.ld_we    = 1'b0;
    bus.dbg_addr = 8'd3;
    bus.malu     = 32'h0000_000C;
    #1;
    chk("t1.dbg",   bus.dbg_data,       32'h1111_1111);
    chk("t1.mmo",   bus.mmo,            32'h1111_1111);
    chk("t1.count", 32'(bus.sb_count),  32'd0);

    // Forwarding while the loader holds the write port
    bus.ld_we   = 1'b1;
    bus.ld_addr = 8'd0;
    bus.ld_data = $urandom;
    bus.mwmem   = 1'b1;
    bus.malu    = 32'h10;
    bus.mb      = 32'hAAAA_0001;
    tick();
    bus.mwmem    = 1'b0;
    bus.dbg_addr = 8'd4;
    #1;
    chk("t2.mmo_const", bus.mmo, 32'hAAAA_0001);
    check_all("t2");

    // Youngest match wins, then drain
    bus.mwmem = 1'b1;
    bus.malu  = 32'h20;
    bus.mb    = 32'h1;
    tick();
    bus.mb    = 32'h2;
    tick();
    bus.mwmem = 1'b0;
    #1;
    chk("t3.mmo_const", bus.mmo, 32'h2);
    check_all("t3");
    drain();
    bus.dbg_addr = 8'd8;
    #1;
    chk("t3.arr8", bus.dbg_data, 32'h2);
    check_all("t3.drained");

    // Full and backpressure
    bus.ld_we = 1'b1;
    bus.mwmem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.malu = 32'(i * 4);
      bus.mb   = 32'hA0 + 32'(i);
      tick();
    end
    chk("t4.full", 32'(bus.sb_full), 32'd1);
    bus.malu = 32'h10;
    bus.mb   = 32'hA4;
    tick();
    chk("t4.held_count", 32'(bus.sb_count), 32'd4);
    bus.ld_we = 1'b0;
    tick();
    chk("t4.after_pop_full",  32'(bus.sb_full),  32'd0);
    chk("t4.after_pop_count", 32'(bus.sb_count), 32'd3);
    tick();
    chk("t4.accepted_count",  32'(bus.sb_count), 32'd3);
    check_all("t4");
    drain();
    for (int i = 0; i < 5; i++) begin
      bus.dbg_addr = 8'(i);
      #1;
      chk($sformatf("t4.arr%0d", i), bus.dbg_data, 32'hA0 + 32'(i));
    end

    // Reset with stores pending
    bus.ld_we   = 1'b1;
    bus.ld_addr = 8'd200;
    bus.mwmem   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.malu = 32'h40 + 32'(i * 4);
      bus.mb   = $urandom;
      tick();
    end
    bus.mwmem = 1'b0;
    bus.malu  = 32'h44;
    #1;
    check_all("t5.pre");
    resetn = 1'b0;
    #1;
    ref_q.delete();
    chk("t5.count", 32'(bus.sb_count), 32'd0);
    chk("t5.full",  32'(bus.sb_full),  32'd0);
    chk("t5.mmo",   bus.mmo,           ref_mem[8'h11]);
    resetn = 1'b1;
    #1;

    // Address aliasing above AW+1 and low byte bits
    bus.ld_we = 1'b1;
    bus.mwmem = 1'b1;
    bus.malu  = 32'h413;
    bus.mb    = 32'h5;
    tick();
    bus.mwmem = 1'b0;
    bus.malu  = 32'h10;
    #1;
    chk("t6.mmo", bus.mmo, 32'h5);
    drain();
    bus.dbg_addr = 8'd4;
    #1;
    chk("t6.dbg", bus.dbg_data, 32'h5);

    // Randomized traffic over a small window of word indices
    for (int n = 0; n < 400; n++) begin
      if (!(bus.mwmem && !last_accept)) begin
        r         = $urandom;
        bus.mwmem = ($urandom_range(0, 99) < 60);
        bus.malu  = (r & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
        bus.mb    = $urandom;
      end
      bus.ld_we    = ($urandom_range(0, 9) == 0);
      bus.ld_addr  = 8'($urandom_range(0, 15));
      bus.ld_data  = $urandom;
      bus.dbg_addr = 8'($urandom_range(0, 15));
      #1;
      check_all("rand");
      tick();
    end
    drain();
    #1;
    check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
